// File: rtl/btn_debounce_multi.sv
`timescale 1ns/1ps
// Purpose: N-channel push-button conditioner (2-FF sync, tick-based debounce, press/release/toggle/long-press) plus heartbeat LED.
// Latency: 2 clk sync + up to STABLE_TICKS prescaler ticks to accept a level; strobes are registered alongside the new level.
// Backpressure: none; every strobe is a one-clk pulse that downstream logic must catch when it is asserted.
//
// Ports:
//   i_clk           system clock
//   i_rst           asynchronous reset, active-high
//   i_btn_in        raw button pins, asynchronous to i_clk
//   o_btn_level     debounced level per channel, 1 = pressed
//   o_btn_press     one-clk strobe when a press is accepted
//   o_btn_release   one-clk strobe when a release is accepted
//   o_btn_toggle    per-channel latch that inverts on every accepted press
//   o_long_press    one-clk strobe once per hold, LONG_TICKS ticks after the press was accepted
//   o_tick          prescaler strobe, one clk every 2^DIV_BITS clk
//   o_blink         heartbeat, MSB of a free-running counter
module btn_debounce_multi #(
  parameter int N_BTN        = 2,
  parameter int DIV_BITS     = 19,
  parameter int STABLE_TICKS = 4,
  parameter int LONG_TICKS   = 50,
  parameter int ACTIVE_LOW   = 1,
  parameter int BLINK_BITS   = 24
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic [N_BTN-1:0] i_btn_in,
  output logic [N_BTN-1:0] o_btn_level,
  output logic [N_BTN-1:0] o_btn_press,
  output logic [N_BTN-1:0] o_btn_release,
  output logic [N_BTN-1:0] o_btn_toggle,
  output logic [N_BTN-1:0] o_long_press,
  output logic             o_tick,
  output logic             o_blink
);

  // Pin level that means "not pressed"; the synchroniser resets to it so a
  // reset never looks like a press edge.
  localparam logic                  REL_LVL   = (ACTIVE_LOW != 0);
  localparam logic [N_BTN-1:0]      SYNC_RST  = {N_BTN{REL_LVL}};
  localparam logic [DIV_BITS-1:0]   PRESC_ONE = DIV_BITS'(1);
  localparam logic [BLINK_BITS-1:0] BLINK_ONE = BLINK_BITS'(1);
  localparam logic [3:0]            SC_ONE    = 4'(1);
  localparam logic [3:0]            SC_LAST   = 4'(STABLE_TICKS - 1);
  localparam logic [7:0]            HC_ONE    = 8'(1);
  localparam logic [7:0]            HC_MAX    = 8'(LONG_TICKS);
  localparam logic [7:0]            HC_LAST   = 8'(LONG_TICKS - 1);

  // ---------------------------------------------------------------------------
  // Prescaler and heartbeat
  // ---------------------------------------------------------------------------
  logic [DIV_BITS-1:0]   r_presc;
  logic                  r_tick;
  logic [BLINK_BITS-1:0] r_blink;

  // r_tick is registered from the all-ones count, so it is high during the
  // cycle after the counter passes 2^DIV_BITS-1 and debounce logic sees it as
  // a one-cycle enable.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_presc <= '0;
      r_tick  <= 1'b0;
    end else begin
      r_presc <= r_presc + PRESC_ONE;
      r_tick  <= &r_presc;
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_blink <= '0;
    end else begin
      r_blink <= r_blink + BLINK_ONE;
    end
  end

  assign o_tick  = r_tick;
  assign o_blink = r_blink[BLINK_BITS-1];

  // ---------------------------------------------------------------------------
  // Synchroniser
  // ---------------------------------------------------------------------------
  logic [N_BTN-1:0] r_sync1;
  logic [N_BTN-1:0] r_sync2;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_sync1 <= SYNC_RST;
      r_sync2 <= SYNC_RST;
    end else begin
      r_sync1 <= i_btn_in;
      r_sync2 <= r_sync1;
    end
  end

  // ---------------------------------------------------------------------------
  // Debounce, strobes, toggle, long press
  // ---------------------------------------------------------------------------
  logic [N_BTN-1:0] r_level;
  logic [N_BTN-1:0] r_press;
  logic [N_BTN-1:0] r_release;
  logic [N_BTN-1:0] r_toggle;
  logic [N_BTN-1:0] r_long;
  logic [3:0]       r_sc [N_BTN];
  logic [7:0]       r_hc [N_BTN];

  logic [N_BTN-1:0] w_p;          // synchronised pin, 1 = pressed
  logic [N_BTN-1:0] w_diff;       // pin disagrees with accepted level
  logic [N_BTN-1:0] w_sc_last;    // this tick would complete qualification
  logic [N_BTN-1:0] w_accept;     // level flips on this edge
  logic [N_BTN-1:0] w_long_hit;   // hold counter reaches LONG_TICKS on this edge

  assign w_p    = r_sync2 ^ {N_BTN{REL_LVL}};
  assign w_diff = w_p ^ r_level;

  always_comb begin
    w_sc_last  = '0;
    w_long_hit = '0;
    for (int i = 0; i < N_BTN; i++) begin
      w_sc_last[i]  = (r_sc[i] == SC_LAST);
      w_long_hit[i] = r_tick & r_level[i] & (r_hc[i] == HC_LAST);
    end
  end

  assign w_accept = w_diff & w_sc_last & {N_BTN{r_tick}};

  // Level and strobes: the strobes are loaded on the same edge that flips
  // r_level, so they line up with the new level on the outputs.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_level   <= '0;
      r_press   <= '0;
      r_release <= '0;
      r_toggle  <= '0;
      r_long    <= '0;
    end else begin
      r_level   <= r_level ^ w_accept;
      r_press   <= w_accept & w_p;
      r_release <= w_accept & ~w_p;
      r_toggle  <= r_toggle ^ (w_accept & w_p);
      r_long    <= w_long_hit;
    end
  end

  // Stable counter: any cycle where the pin agrees with the accepted level
  // restarts qualification, so a bounce between ticks is enough to reset it.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      for (int i = 0; i < N_BTN; i++) begin
        r_sc[i] <= '0;
      end
    end else begin
      for (int i = 0; i < N_BTN; i++) begin
        if (!w_diff[i]) begin
          r_sc[i] <= '0;
        end else if (r_tick) begin
          r_sc[i] <= w_sc_last[i] ? 4'd0 : (r_sc[i] + SC_ONE);
        end
      end
    end
  end

  // Hold counter saturates at LONG_TICKS so long press fires once per hold.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      for (int i = 0; i < N_BTN; i++) begin
        r_hc[i] <= '0;
      end
    end else begin
      for (int i = 0; i < N_BTN; i++) begin
        if (!r_level[i]) begin
          r_hc[i] <= '0;
        end else if (r_tick && (r_hc[i] < HC_MAX)) begin
          r_hc[i] <= r_hc[i] + HC_ONE;
        end
      end
    end
  end

  assign o_btn_level   = r_level;
  assign o_btn_press   = r_press;
  assign o_btn_release = r_release;
  assign o_btn_toggle  = r_toggle;
  assign o_long_press  = r_long;

endmodule
